uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART Tx line between several message sources, e.g. the "signal not detected" text generator and the CORDIC angle/direction report formatter.
- Each requester offers a byte stream (valid/ready/last). The arbiter grants one requester per packet, round-robin, and serializes bytes at 8N1.
- Sits between the message generators and the board Tx pin; the generators no longer drive Tx directly.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200).
- GAP_CYCLES, 16, idle-high cycles inserted after each packet before the next arbitration.
- TIMEOUT_CYCLES, 65535, stall limit for a granted requester (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its data slice
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of requester i's packet
- req_ready  out  NUM_REQ  one-cycle accept strobe; a byte transfers when valid&ready
- grant  out  NUM_REQ  one-hot owner of the line; zero when idle
- busy  out  1  high from grant until the GAP state is left
- end_trs  out  1  one-cycle pulse after the stop bit of a packet's last byte
- Tx  out  1  serial line, idle high

Behaviour:
- Reset values: Tx=1, grant=0, req_ready=0, busy=0, end_trs=0, rr_ptr=0; state=IDLE.
- Reset mid-operation: on the next edge Tx=1 and all outputs return to reset values. The partial frame is dropped, with no completion stop bit.
- FSM states: IDLE, GRANT, LOAD, SEND, GAP.
- IDLE: if any req_valid, pick the first set bit searching from rr_ptr upward with wrap, set grant one-hot and busy=1, then go to GRANT. Simultaneous requests resolve by this rotation only.
- GRANT: wait for req_valid of the granted requester. When it is high, pulse req_ready for one cycle, latch data and last, then go to LOAD. Bytes are never taken from a non-granted requester.
- LOAD: drive Tx=0 (start bit) for BAUD_DIV cycles. Tx falls on the cycle after the accept.
- SEND: 8 data bits LSB-first, then stop bit Tx=1, each BAUD_DIV cycles. The frame is exactly 10*BAUD_DIV cycles.
- After the stop bit, if the byte was not last, go to GRANT. If the granted valid is already high, the next start bit begins 2 cycles after the stop bit ends (ready cycle + load).
- After the stop bit of the last byte: pulse end_trs, clear grant, set rr_ptr = granted index + 1 (mod NUM_REQ), go to GAP.
- GAP: Tx=1 for GAP_CYCLES, then busy=0 and go to IDLE. GAP_CYCLES=0 goes directly to IDLE.
- The grant is held for the whole packet. Other requesters' valid is ignored until end_trs.
- A granted requester that drops valid mid-packet keeps the grant, with Tx held idle high, indefinitely (unless ARB_TIMEOUT_EN).
- Baud counter width is clog2(BAUD_DIV). It counts 0..BAUD_DIV-1 and wraps to 0 on each bit advance.

Optional Feature:
- ARB_TIMEOUT_EN defined: in GRANT, a stall counter runs while the granted valid is low.
  - At TIMEOUT_CYCLES it releases the grant, advances rr_ptr, and goes to GAP with no end_trs pulse.
  - The counter clears on each accept.
- ARB_TIMEOUT_EN undefined: no counter logic; a stalled grant is held forever.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE..GAP).
  - The BAUD_DIV default 868.
  - The 8N1 frame constants (DATA_BITS=8, FRAME_BITS=10).
- One sub-module, uart_byte_tx: byte load/start strobe in; Tx and frame-done out; holds the baud counter and shift register.
- The arbiter holds the FSM, rr_ptr, grant and gap logic.

Test Plan (BAUD_DIV=4, GAP_CYCLES=2, NUM_REQ=2):
- Single byte from req0, data 0x53, last=1.
  - Tx=0 for 4 cycles, then 1,1,0,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles.
  - end_trs pulses once; grant returns to 0; busy drops 2 cycles later.
- Both valid in the same cycle after reset: req0 granted first, then req1.
  - A repeat of simultaneous requests grants req1 first (rr_ptr=1).
- req0 sends a 3-byte packet ("S","e","m") while req1 raises valid during byte 1.
  - req1 is not granted until after req0's end_trs.
  - Inter-byte spacing: 2 idle-high cycles between stop end and next start.
- rst asserted during data bit 3 of a frame: next cycle Tx=1, grant=0, busy=0.
  - After release, a new request starts a fresh full frame.
- req0 drops valid after byte 1 of 2 (not last).
  - Without the macro: grant stays 0b01 and Tx stays high for 1000 cycles.
  - With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20: grant clears 20 cycles after the stop bit, with no end_trs, and req1 is granted next.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART Tx arbiter and its byte serializer.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_SEND,
    S_GAP
  } arb_state_e;

  // 100 MHz / 115200 baud
  localparam int unsigned BAUD_DIV_DEF = 868;

  // 8N1 framing: start + 8 data + stop
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: a start strobe loads one byte, Tx shifts it out LSB-first
// with a start and stop bit, each BAUD_DIV clocks long. frame_done is high in
// the last cycle of the stop bit; bit_adv is high in the last cycle of any bit.
module uart_byte_tx
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx,
  output logic                 bit_adv,
  output logic                 frame_done
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic                 active_q, active_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS:0]   shift_q, shift_d;  // remaining data bits plus stop bit
  logic                 tx_q, tx_d;
  logic                 wrap;

  // Baud timing and bit shifting; Tx is registered so it changes on bit boundaries only.
  always_comb begin
    active_d   = active_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    wrap       = active_q && (baud_q == BAUD_MAX);
    bit_adv    = wrap;
    frame_done = wrap && (bit_q == BIT_LAST);
    if (start) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {1'b1, data_i};
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (wrap) begin
        baud_d = '0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[DATA_BITS:1]};
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial frame and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx line between NUM_REQ byte-stream sources.
// A grant is held for a whole packet (until a byte with req_last), followed by
// GAP_CYCLES of idle line before the next arbitration.
// Optional: define ARB_TIMEOUT_EN to release a grant whose owner stalls for
// TIMEOUT_CYCLES in GRANT (no end_trs pulse on such a release).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned BAUD_DIV       = BAUD_DIV_DEF,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   end_trs,
  output logic                   Tx
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic               busy_q, busy_d;
  logic               end_q, end_d;
  logic               last_q, last_d;
  logic [GW-1:0]      gap_q, gap_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
  logic [SW-1:0] stall_q, stall_d;
`endif

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] idx_nxt;
  logic          gvalid;
  logic          start_w;
  logic          rel;
  logic [7:0]    byte_data;
  logic          bit_adv;
  logic          frame_done;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign gvalid    = req_valid[gidx_q];
  assign byte_data = req_data[int'(gidx_q)*8 +: 8];
  assign idx_nxt   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
  // A byte transfers in the cycle the registered ready pulse meets the owner's valid.
  assign start_w   = (state_q == S_GRANT) && (|ready_q) && gvalid;

  // Arbiter next-state logic; rel covers both packet end and stall release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ready_d = '0;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    end_d   = 1'b0;
    last_d  = last_q;
    gap_d   = gap_q;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (start_w) begin
          last_d  = req_last[gidx_q];
          state_d = S_LOAD;
        end else if (gvalid && !(|ready_q)) begin
          ready_d = grant_q;
        end
`ifdef ARB_TIMEOUT_EN
        stall_d = stall_q;
        if (start_w) begin
          stall_d = '0;
        end else if (!gvalid) begin
          if (stall_q == STALL_LAST) rel = 1'b1;
          else stall_d = stall_q + 1'b1;
        end
`endif
      end
      S_LOAD: begin
        if (bit_adv) state_d = S_SEND;
      end
      S_SEND: begin
        if (frame_done) begin
          if (last_q) begin
            end_d = 1'b1;
            rel   = 1'b1;
          end else begin
            state_d = S_GRANT;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rel) begin
      grant_d = '0;
      ready_d = '0;
      rr_d    = idx_nxt;
      gap_d   = '0;
      if (GAP_CYCLES == 0) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        state_d = S_GAP;
      end
    end
  end

  // Arbiter registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      last_q  <= 1'b0;
      gap_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
`ifdef ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (start_w),
    .data_i     (byte_data),
    .tx         (Tx),
    .bit_adv    (bit_adv),
    .frame_done (frame_done)
  );

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign end_trs   = end_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the inputs, a
// serial receiver decodes Tx and checks each byte and its owner against the
// expected-byte queue filled when stimulus is issued.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int BD = 4;
  localparam int GC = 2;
  localparam int TO = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              end_trs;
  logic              Tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .BAUD_DIV       (BD),
    .GAP_CYCLES     (GC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .end_trs   (end_trs),
    .Tx        (Tx)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [15:0] exp_q[$];   // {owner one-hot, data byte}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    if (r == 0) src0.push_back({l, d});
    else        src1.push_back({l, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    exp_q.push_back({8'(1 << r), d});
  endtask

  task automatic wait_low(input int budget);
    int c = 0;
    while (Tx !== 1'b0 && c < budget) begin
      tick();
      c++;
    end
    chk("tmo_start_bit", 32'(c >= budget), 0);
  endtask

  task automatic wait_busy(input int budget);
    int c = 0;
    while (busy !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    chk("tmo_busy", 32'(c >= budget), 0);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && src0.size() == 0 && src1.size() == 0)
           && c < budget) begin
      tick();
      c++;
    end
    chk("tmo_drain", 32'(c >= budget), 0);
  endtask

  // Full-frame bit check from req0, plus end-of-packet/gap timing.
  task automatic frame_check(input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    wait_low(200);
    chk("own_at_start", grant, 2'b01);
    chk("busy_at_start", busy, 1);
    for (int t = 0; t < 10*BD; t++) begin
      chk("tx_bit", Tx, fr[t/BD]);
      tick();
    end
    chk("end_pulse", end_trs, 1);
    chk("grant_clear", grant, 0);
    chk("busy_in_gap", busy, 1);
    chk("idle_after", Tx, 1);
    tick();
    chk("end_one_cycle", end_trs, 0);
    chk("busy_gap2", busy, 1);
    tick();
    chk("busy_drop", busy, 0);
  endtask

  // Requester models: present queue head, pop on valid&ready at the edge.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      if (rst === 1'b0) begin
        if (req_valid[0] && req_ready[0] && src0.size() > 0) src0.delete(0);
        if (req_valid[1] && req_ready[1] && src1.size() > 0) src1.delete(0);
      end
      #1;
      req_valid[0]   = src0.size() > 0;
      req_last[0]    = (src0.size() > 0) ? src0[0][8] : 1'b0;
      req_data[7:0]  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
      req_valid[1]   = src1.size() > 0;
      req_last[1]    = (src1.size() > 0) ? src1[0][8] : 1'b0;
      req_data[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
    end
  end

  // Serial receiver / scoreboard consumer.
  int            rx_st = 0;
  int            rx_t  = 0;
  int            rx_j  = 0;
  logic [7:0]    rx_sh;
  logic [NR-1:0] rx_g;
  logic [15:0]   rx_e;

  initial begin
    forever begin
      tick();
      if (rst !== 1'b0) begin
        rx_st = 0;
      end else if (rx_st == 0) begin
        if (Tx === 1'b0) begin
          rx_st = 1;
          rx_t  = 0;
          rx_g  = grant;
          rx_sh = '0;
        end
      end else begin
        rx_t++;
        if (rx_t % BD == BD/2) begin
          rx_j = rx_t / BD;
          if (rx_j == 0) begin
            chk("rx_start", Tx, 0);
          end else if (rx_j <= 8) begin
            rx_sh[rx_j-1] = Tx;
          end else begin
            chk("rx_stop", Tx, 1);
            if (exp_q.size() == 0) begin
              chk("sb_underflow", exp_q.size(), 1);
            end else begin
              rx_e = exp_q.pop_front();
              chk("sb_byte", {rx_g, rx_sh}, rx_e);
            end
            rx_st = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int   n_end;
  logic all_hi;
  logic hold;

  initial begin
    // reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tx", Tx, 1);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_end", end_trs, 0);
    rst = 1'b0;
    tick();

    // single byte 0x53 from req0
    push_src(0, 8'h53, 1'b1);
    expect_byte(0, 8'h53);
    frame_check(8'h53);
    wait_drain(100);

    // simultaneous requests after reset: req0 then req1
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    push_src(0, 8'hA1, 1'b1);
    push_src(1, 8'hB2, 1'b1);
    expect_byte(0, 8'hA1);
    expect_byte(1, 8'hB2);
    wait_busy(20);
    chk("rr_first", grant, 2'b01);
    wait_drain(300);
    // req0 alone leaves rr_ptr at 1
    push_src(0, 8'h11, 1'b1);
    expect_byte(0, 8'h11);
    wait_drain(200);
    push_src(0, 8'hC3, 1'b1);
    push_src(1, 8'hD4, 1'b1);
    expect_byte(1, 8'hD4);
    expect_byte(0, 8'hC3);
    wait_busy(20);
    chk("rr_rotate", grant, 2'b10);
    wait_drain(300);

    // 3-byte packet from req0 while req1 raises valid
    push_src(0, 8'h53, 1'b0);
    push_src(0, 8'h65, 1'b0);
    push_src(0, 8'h6D, 1'b1);
    expect_byte(0, 8'h53);
    expect_byte(0, 8'h65);
    expect_byte(0, 8'h6D);
    wait_low(200);
    for (int t = 0; t <= 130; t++) begin
      if (t == 10) begin
        push_src(1, 8'h21, 1'b1);
        expect_byte(1, 8'h21);
      end
      if (t == 40 || t == 41) chk("byte_gap_high", Tx, 1);
      if (t == 42)  chk("byte2_start", Tx, 0);
      if (t == 60)  chk("hold_grant", grant, 2'b01);
      if (t == 84)  chk("byte3_start", Tx, 0);
      if (t == 123) chk("no_early_end", end_trs, 0);
      if (t == 124) begin
        chk("pkt_end", end_trs, 1);
        chk("pkt_grant_clr", grant, 0);
      end
      if (t == 126) chk("gap_no_grant", grant, 0);
      if (t == 127) chk("req1_after", grant, 2'b10);
      tick();
    end
    wait_drain(300);

    // reset during data bit 3
    push_src(0, 8'h5A, 1'b1);
    expect_byte(0, 8'h5A);
    wait_low(200);
    repeat (17) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", Tx, 1);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_end", end_trs, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    push_src(0, 8'hC5, 1'b1);
    expect_byte(0, 8'hC5);
    frame_check(8'hC5);
    wait_drain(100);

    // owner stalls after byte 1 of 2
    push_src(0, 8'h77, 1'b0);
    expect_byte(0, 8'h77);
    wait_low(200);
    repeat (40) tick();
`ifdef ARB_TIMEOUT_EN
    n_end = 0;
    for (int t = 40; t <= 63; t++) begin
      if (t == 45) begin
        push_src(1, 8'h88, 1'b1);
        expect_byte(1, 8'h88);
      end
      if (end_trs === 1'b1) n_end++;
      if (t == 40) chk("to_grant_held", grant, 2'b01);
      if (t == 59) chk("to_grant_59", grant, 2'b01);
      if (t == 60) chk("to_release", grant, 0);
      if (t == 63) chk("to_next_owner", grant, 2'b10);
      tick();
    end
    chk("to_no_end", n_end, 0);
    wait_drain(300);
`else
    all_hi = 1'b1;
    hold   = 1'b1;
    n_end  = 0;
    repeat (1000) begin
      tick();
      all_hi = all_hi & (Tx === 1'b1);
      hold   = hold & (grant === 2'b01);
      if (end_trs === 1'b1) n_end++;
    end
    chk("stall_tx_high", all_hi, 1);
    chk("stall_grant_held", hold, 1);
    chk("stall_no_end", n_end, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
